accel_moving_average: RTL and testbench



---
 rtl/accel_moving_average.sv | 193 +++++++++++++++++++
 tb/tb_accel_moving_average.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_moving_average.sv
// -----------------------------------------------------------------------------
// accel_moving_average
//
// Per-axis sliding-window boxcar filter for the raw IMU accelerometer words.
// A rising edge on DataValid accepts one X/Y/Z sample. Each axis keeps a
// running sum over the last 2^LOG2_N samples. The smoothed averages appear
// exactly two cycles after the accepted edge, together with a one-cycle
// AvgValid pulse. The window starts zero-filled, so early averages still
// divide by N and are pulled toward zero until the window is full.
//
// Ports:
//   CLOCK_50   in   1       system clock; all state changes on its rising edge
//   RESET      in   1       synchronous reset, active high
//   AccelX/Y/Z in   DATA_W  raw signed samples; only need to be stable in the
//                           cycle in which the DataValid edge is seen
//   DataValid  in   1       new-sample level; only its rising edge is used
//   AvgX/Y/Z   out  DATA_W  signed windowed averages (floor of sum / N);
//                           held between pulses
//   AvgValid   out  1       one-cycle pulse when Avg* were just updated
//   Primed     out  1       high once N samples have entered since reset
// -----------------------------------------------------------------------------
module accel_moving_average #(
    parameter int DATA_W = 12,
    parameter int LOG2_N = 3
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET,
    input  logic signed [DATA_W-1:0] AccelX,
    input  logic signed [DATA_W-1:0] AccelY,
    input  logic signed [DATA_W-1:0] AccelZ,
    input  logic                     DataValid,
    output logic signed [DATA_W-1:0] AvgX,
    output logic signed [DATA_W-1:0] AvgY,
    output logic signed [DATA_W-1:0] AvgZ,
    output logic                     AvgValid,
    output logic                     Primed
);

    localparam int N      = 1 << LOG2_N;
    localparam int SUM_W  = DATA_W + LOG2_N;
    localparam int N_AXIS = 3;

    typedef logic [LOG2_N-1:0] ptr_t;
    typedef logic [LOG2_N:0]   fill_t;

    localparam fill_t FILL_FULL = fill_t'(N);
    localparam fill_t FILL_LAST = fill_t'(N - 1);

    // Sign-extends a sample to the running-sum width.
    function automatic logic signed [SUM_W-1:0] sext_sample(
        input logic signed [DATA_W-1:0] v
    );
        return {{LOG2_N{v[DATA_W-1]}}, v};
    endfunction

    // Input edge detection
    logic                     dv_d_r;
    logic                     edge_s;

    // Stage 1: captured new sample and the sample leaving the window
    logic                     s1_valid_r;
    logic signed [DATA_W-1:0] new_r [N_AXIS];
    logic signed [DATA_W-1:0] old_r [N_AXIS];

    // Window state
    logic signed [DATA_W-1:0] buf_r [N_AXIS][N];
    logic signed [SUM_W-1:0]  sum_r [N_AXIS];
    logic signed [SUM_W-1:0]  sum_next_s [N_AXIS];
    ptr_t                     wr_ptr_r;
    fill_t                    fill_r;

    // Output registers
    logic signed [DATA_W-1:0] avg_r [N_AXIS];
    logic                     avg_valid_r;
    logic                     primed_r;

    // Raw inputs gathered per axis so the datapath can loop over axes
    logic signed [DATA_W-1:0] sample_s [N_AXIS];

    // Gather the three axis inputs into an indexable array.
    always_comb begin
        sample_s[0] = AccelX;
        sample_s[1] = AccelY;
        sample_s[2] = AccelZ;
    end

    // Only a low-to-high transition of the DataValid level is a new sample;
    // dv_d_r clears on reset so a high level right after reset counts.
    assign edge_s = DataValid & ~dv_d_r;

    // Running sum after the new sample enters and the oldest one leaves.
    // The sum holds at most N full-scale samples, so SUM_W bits never wrap.
    always_comb begin
        for (int a = 0; a < N_AXIS; a++) begin
            sum_next_s[a] = sum_r[a] + sext_sample(new_r[a]) - sext_sample(old_r[a]);
        end
    end

    // Edge detector and stage 1: capture the new sample and read the entry it replaces.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            dv_d_r     <= 1'b0;
            s1_valid_r <= 1'b0;
            for (int a = 0; a < N_AXIS; a++) begin
                new_r[a] <= {DATA_W{1'b0}};
                old_r[a] <= {DATA_W{1'b0}};
            end
        end else begin
            dv_d_r     <= DataValid;
            s1_valid_r <= edge_s;
            if (edge_s) begin
                for (int a = 0; a < N_AXIS; a++) begin
                    new_r[a] <= sample_s[a];
                    // wr_ptr_r already reflects any stage-2 write of the
                    // previous sample, because edges are at least two cycles apart.
                    old_r[a] <= buf_r[a][wr_ptr_r];
                end
            end else begin
                for (int a = 0; a < N_AXIS; a++) begin
                    new_r[a] <= new_r[a];
                    old_r[a] <= old_r[a];
                end
            end
        end
    end

    // Stage 2: update sums, overwrite the oldest entry and advance the pointer.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            wr_ptr_r <= ptr_t'(0);
            fill_r   <= fill_t'(0);
            for (int a = 0; a < N_AXIS; a++) begin
                sum_r[a] <= {SUM_W{1'b0}};
                for (int i = 0; i < N; i++) begin
                    buf_r[a][i] <= {DATA_W{1'b0}};
                end
            end
        end else if (s1_valid_r) begin
            // Pointer width equals LOG2_N, so the increment wraps modulo N.
            wr_ptr_r <= wr_ptr_r + ptr_t'(1);
            if (fill_r != FILL_FULL) begin
                fill_r <= fill_r + fill_t'(1);
            end else begin
                fill_r <= fill_r;
            end
            for (int a = 0; a < N_AXIS; a++) begin
                sum_r[a]              <= sum_next_s[a];
                buf_r[a][wr_ptr_r]    <= new_r[a];
            end
        end else begin
            wr_ptr_r <= wr_ptr_r;
            fill_r   <= fill_r;
        end
    end

    // Output stage: averages, valid pulse and primed flag, all registered.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            avg_valid_r <= 1'b0;
            primed_r    <= 1'b0;
            for (int a = 0; a < N_AXIS; a++) begin
                avg_r[a] <= {DATA_W{1'b0}};
            end
        end else begin
            avg_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                // Dropping the low LOG2_N bits of a two's-complement sum is an
                // arithmetic shift, i.e. floor division by N.
                for (int a = 0; a < N_AXIS; a++) begin
                    avg_r[a] <= sum_next_s[a][SUM_W-1:LOG2_N];
                end
                // Rises together with the pulse of the Nth sample.
                if (fill_r >= FILL_LAST) begin
                    primed_r <= 1'b1;
                end else begin
                    primed_r <= primed_r;
                end
            end else begin
                primed_r <= primed_r;
                for (int a = 0; a < N_AXIS; a++) begin
                    avg_r[a] <= avg_r[a];
                end
            end
        end
    end

    assign AvgX     = avg_r[0];
    assign AvgY     = avg_r[1];
    assign AvgZ     = avg_r[2];
    assign AvgValid = avg_valid_r;
    assign Primed   = primed_r;

endmodule

// File: tb/tb_accel_moving_average.sv
// -----------------------------------------------------------------------------
// tb_accel_moving_average
//
// Drives DataValid edges with random and directed sample values and compares
// the DUT against a reference window kept as plain integer arrays: the
// expected average is the floor of the integer sum of the last eight samples
// divided by eight.
// -----------------------------------------------------------------------------
module tb_accel_moving_average;

    localparam int DATA_W = 12;
    localparam int NWIN   = 8;

    logic                     CLOCK_50;
    logic                     RESET;
    logic signed [DATA_W-1:0] AccelX;
    logic signed [DATA_W-1:0] AccelY;
    logic signed [DATA_W-1:0] AccelZ;
    logic                     DataValid;
    logic signed [DATA_W-1:0] AvgX;
    logic signed [DATA_W-1:0] AvgY;
    logic signed [DATA_W-1:0] AvgZ;
    logic                     AvgValid;
    logic                     Primed;

    int checks;
    int errors;

    // Reference model state
    int win [3][NWIN];
    int wptr;
    int fill;

    accel_moving_average #(.DATA_W(DATA_W), .LOG2_N(3)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .AccelX    (AccelX),
        .AccelY    (AccelY),
        .AccelZ    (AccelZ),
        .DataValid (DataValid),
        .AvgX      (AvgX),
        .AvgY      (AvgY),
        .AvgZ      (AvgZ),
        .AvgValid  (AvgValid),
        .Primed    (Primed)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic signed [DATA_W-1:0] rnd_sample();
        return DATA_W'($urandom);
    endfunction

    function automatic int floor_div8(input int s);
        int q;
        q = s / NWIN;
        if ((s % NWIN) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        for (int a = 0; a < 3; a++)
            for (int i = 0; i < NWIN; i++) win[a][i] = 0;
        wptr = 0;
        fill = 0;
    endtask

    task automatic model_push(input int x, input int y, input int z,
                              output int ex, output int ey, output int ez,
                              output bit ep);
        int s [3];
        win[0][wptr] = x;
        win[1][wptr] = y;
        win[2][wptr] = z;
        wptr = (wptr + 1) % NWIN;
        fill = fill + 1;
        for (int a = 0; a < 3; a++) begin
            s[a] = 0;
            for (int i = 0; i < NWIN; i++) s[a] = s[a] + win[a][i];
        end
        ex = floor_div8(s[0]);
        ey = floor_div8(s[1]);
        ez = floor_div8(s[2]);
        ep = (fill >= NWIN);
    endtask

    task automatic apply_reset();
        RESET     = 1'b1;
        DataValid = 1'b0;
        AccelX    = rnd_sample();
        AccelY    = rnd_sample();
        AccelZ    = rnd_sample();
        step();
        step();
        RESET = 1'b0;
        model_clear();
    endtask

    // One accepted edge: DataValid high for one cycle, then low with scrambled
    // data. Returns the valid flag one cycle after the edge and the outputs
    // two cycles after the edge. Ends with DataValid low, ready for the next edge.
    task automatic push(input logic signed [DATA_W-1:0] x,
                        input logic signed [DATA_W-1:0] y,
                        input logic signed [DATA_W-1:0] z,
                        output bit v_mid, output bit v_out,
                        output int ox, output int oy, output int oz,
                        output bit pr);
        DataValid = 1'b1;
        AccelX = x;
        AccelY = y;
        AccelZ = z;
        step();
        v_mid = AvgValid;
        DataValid = 1'b0;
        AccelX = rnd_sample();
        AccelY = rnd_sample();
        AccelZ = rnd_sample();
        step();
        v_out = AvgValid;
        ox = int'(AvgX);
        oy = int'(AvgY);
        oz = int'(AvgZ);
        pr = Primed;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (AvgX !== 12'sd0 || AvgY !== 12'sd0 || AvgZ !== 12'sd0) begin
            errors++;
            $display("FAIL reset_avg: got %0d/%0d/%0d expected 0/0/0", AvgX, AvgY, AvgZ);
        end
        checks++;
        if (AvgValid !== 1'b0 || Primed !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b primed=%b expected 0/0", AvgValid, Primed);
        end
    endtask

    task automatic test_fill_constant();
        int table_x [NWIN] = '{12, 25, 37, 50, 62, 75, 87, 100};
        bit vm, vo, pr, ep;
        int ox, oy, oz, ex, ey, ez;
        logic signed [DATA_W-1:0] y, z;
        apply_reset();
        for (int k = 0; k < NWIN; k++) begin
            y = rnd_sample();
            z = rnd_sample();
            push(12'sd100, y, z, vm, vo, ox, oy, oz, pr);
            model_push(100, int'(y), int'(z), ex, ey, ez, ep);
            checks++;
            if (vm !== 1'b0 || vo !== 1'b1) begin
                errors++;
                $display("FAIL fill_latency[%0d]: got valid T+1=%b T+2=%b expected 0/1", k, vm, vo);
            end
            checks++;
            if (ox != table_x[k] || ox != ex) begin
                errors++;
                $display("FAIL fill_avgx[%0d]: got %0d expected %0d", k, ox, table_x[k]);
            end
            checks++;
            if (oy != ey || oz != ez) begin
                errors++;
                $display("FAIL fill_avgyz[%0d]: got %0d/%0d expected %0d/%0d", k, oy, oz, ey, ez);
            end
            checks++;
            if (pr !== ep) begin
                errors++;
                $display("FAIL fill_primed[%0d]: got %b expected %b", k, pr, ep);
            end
        end
    endtask

    task automatic test_negative_single();
        bit vm, vo, pr;
        int ox, oy, oz;
        apply_reset();
        push(12'sd0, -12'sd100, 12'sd0, vm, vo, ox, oy, oz, pr);
        checks++;
        if (vo !== 1'b1 || oy != -13) begin
            errors++;
            $display("FAIL neg_avgy: got valid=%b avg=%0d expected 1/-13", vo, oy);
        end
        step();
        checks++;
        if (AvgValid !== 1'b0 || int'(AvgY) != -13) begin
            errors++;
            $display("FAIL neg_pulse_hold: got valid=%b avg=%0d expected 0/-13", AvgValid, AvgY);
        end
    endtask

    task automatic test_window_wrap();
        bit vm, vo, pr, ep;
        int ox, oy, oz, ex, ey, ez;
        logic signed [DATA_W-1:0] x;
        apply_reset();
        for (int k = 0; k < 2 * NWIN; k++) begin
            x = rnd_sample();
            push(x, 12'sd0, (k < NWIN) ? 12'sd0 : 12'sd800, vm, vo, ox, oy, oz, pr);
            model_push(int'(x), 0, (k < NWIN) ? 0 : 800, ex, ey, ez, ep);
            checks++;
            if (vo !== 1'b1 || oz != ez || ox != ex) begin
                errors++;
                $display("FAIL wrap[%0d]: got valid=%b z=%0d x=%0d expected 1/%0d/%0d", k, vo, oz, ox, ez, ex);
            end
            if (k == NWIN + 3) begin
                checks++;
                if (oz != 400) begin
                    errors++;
                    $display("FAIL wrap_half: got %0d expected 400", oz);
                end
            end
        end
        checks++;
        if (oz != 800) begin
            errors++;
            $display("FAIL wrap_full: got %0d expected 800", oz);
        end
    endtask

    task automatic test_extremes();
        bit vm, vo, pr, ep;
        int ox, oy, oz, ex, ey, ez;
        apply_reset();
        for (int k = 0; k < 2 * NWIN; k++) begin
            push((k < NWIN) ? 12'sd2047 : -12'sd2048, -12'sd2048, 12'sd2047,
                 vm, vo, ox, oy, oz, pr);
            model_push((k < NWIN) ? 2047 : -2048, -2048, 2047, ex, ey, ez, ep);
            checks++;
            if (ox != ex || oy != ey || oz != ez) begin
                errors++;
                $display("FAIL extreme[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", k, ox, oy, oz, ex, ey, ez);
            end
        end
        checks++;
        if (ox != -2048 || oy != -2048 || oz != 2047) begin
            errors++;
            $display("FAIL extreme_final: got %0d/%0d/%0d expected -2048/-2048/2047", ox, oy, oz);
        end
    endtask

    task automatic test_held_level();
        int pulses, cap_x, cap_y, cap_z, ex, ey, ez;
        bit ep;
        logic signed [DATA_W-1:0] x, y, z;
        x = rnd_sample();
        y = rnd_sample();
        z = rnd_sample();
        model_push(int'(x), int'(y), int'(z), ex, ey, ez, ep);
        DataValid = 1'b1;
        AccelX = x;
        AccelY = y;
        AccelZ = z;
        pulses = 0;
        cap_x = 0;
        cap_y = 0;
        cap_z = 0;
        for (int c = 0; c < 14; c++) begin
            step();
            if (c == 9) DataValid = 1'b0;
            AccelX = rnd_sample();
            AccelY = rnd_sample();
            AccelZ = rnd_sample();
            if (AvgValid === 1'b1) begin
                pulses++;
                cap_x = int'(AvgX);
                cap_y = int'(AvgY);
                cap_z = int'(AvgZ);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL held_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (cap_x != ex || cap_y != ey || cap_z != ez) begin
            errors++;
            $display("FAIL held_avg: got %0d/%0d/%0d expected %0d/%0d/%0d", cap_x, cap_y, cap_z, ex, ey, ez);
        end
    endtask

    task automatic test_back_to_back();
        bit vm, vo, pr, ep;
        int ox, oy, oz, ex, ey, ez, pulses, bad;
        logic signed [DATA_W-1:0] x, y, z;
        pulses = 0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            x = rnd_sample();
            y = rnd_sample();
            z = rnd_sample();
            push(x, y, z, vm, vo, ox, oy, oz, pr);
            model_push(int'(x), int'(y), int'(z), ex, ey, ez, ep);
            if (vo === 1'b1) pulses++;
            checks++;
            if (ox != ex || oy != ey || oz != ez || pr !== ep) begin
                errors++;
                bad++;
                $display("FAIL b2b[%0d]: got %0d/%0d/%0d p=%b expected %0d/%0d/%0d p=%b",
                         k, ox, oy, oz, pr, ex, ey, ez, ep);
            end
        end
        checks++;
        if (pulses != 20) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d expected 20", pulses);
        end
    endtask

    task automatic test_reset_midflight();
        bit vm, vo, pr, ep, seen;
        int ox, oy, oz, ex, ey, ez;
        checks++;
        if (Primed !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_primed: got %b expected 1", Primed);
        end
        DataValid = 1'b1;
        AccelX = rnd_sample();
        AccelY = rnd_sample();
        AccelZ = rnd_sample();
        step();
        RESET = 1'b1;
        DataValid = 1'b0;
        step();
        RESET = 1'b0;
        model_clear();
        checks++;
        if (AvgX !== 12'sd0 || AvgY !== 12'sd0 || AvgZ !== 12'sd0 || Primed !== 1'b0) begin
            errors++;
            $display("FAIL mid_cleared: got %0d/%0d/%0d primed=%b expected 0/0/0 primed=0", AvgX, AvgY, AvgZ, Primed);
        end
        seen = (AvgValid === 1'b1);
        for (int c = 0; c < 4; c++) begin
            step();
            if (AvgValid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_no_valid: got pulse expected none");
        end
        push(12'sd80, 12'sd0, 12'sd0, vm, vo, ox, oy, oz, pr);
        model_push(80, 0, 0, ex, ey, ez, ep);
        checks++;
        if (vo !== 1'b1 || ox != 10 || ox != ex || pr !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: got valid=%b x=%0d primed=%b expected 1/10/0", vo, ox, pr);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        RESET     = 1'b1;
        DataValid = 1'b0;
        AccelX    = 12'sd0;
        AccelY    = 12'sd0;
        AccelZ    = 12'sd0;
        model_clear();
        test_reset();
        test_fill_constant();
        test_negative_single();
        test_window_wrap();
        test_extremes();
        test_held_level();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
